// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : burst-size encodings, burst-length decode and responder states
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [1:0] SIZE_1  = 2'b00;
    localparam logic [1:0] SIZE_4  = 2'b01;
    localparam logic [1:0] SIZE_8  = 2'b10;
    localparam logic [1:0] SIZE_16 = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD_BURST = 2'd1;
    localparam logic [1:0] ST_WR_BURST = 2'd2;

    function automatic logic [4:0] burst_len(input logic [1:0] size);
        logic [4:0] len;
        case (size)
            SIZE_1:  len = 5'd1;
            SIZE_4:  len = 5'd4;
            SIZE_8:  len = 5'd8;
            SIZE_16: len = 5'd16;
            default: len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_word_array.sv
// ============================================================================
// mem_word_array : synchronous single-port word storage, one access per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_word_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_burst_responder.sv
// ============================================================================
// mem_burst_responder : burst read/write responder over a word array.
// Optional macro MEM_RANGE_CHECK_EN rejects out-of-range bursts with an error
// pulse; otherwise indices wrap modulo DEPTH_WORDS.   Rev 1.0
// ============================================================================
`default_nettype none

module mem_burst_responder
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h80020000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]       r_state;
    logic [3:0]       r_beats_left;
    logic [IDX_W-1:0] r_next_idx;
    logic             r_data_valid;
    logic             r_error;

    logic             w_idle;
    logic             w_reject;
    logic             w_accept;
    logic             w_rd_beat;
    logic             w_wr_beat;
    logic [3:0]       w_len_m1;
    logic [IDX_W-1:0] w_start_idx;
    logic [IDX_W-1:0] w_beat_idx;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_len_m1    = 4'(burst_len(access_size) - 5'd1);
    assign w_start_idx = IDX_W'((address - BASE_ADDR) >> 2);

`ifdef MEM_RANGE_CHECK_EN
    logic [ADDR_WIDTH:0] w_last_word;

    // One extra bit so start+N-1 cannot overflow past the depth compare.
    assign w_last_word = {1'b0, (address - BASE_ADDR) >> 2} + (ADDR_WIDTH+1)'(w_len_m1);
    assign w_reject    = (address < BASE_ADDR) ||
                         (w_last_word >= (ADDR_WIDTH+1)'(DEPTH_WORDS));
`else
    assign w_reject    = 1'b0;
`endif

    assign w_accept   = w_idle && enable && !w_reject;
    assign w_rd_beat  = w_accept ? rw  : (r_state == ST_RD_BURST);
    assign w_wr_beat  = w_accept ? !rw : (r_state == ST_WR_BURST);
    assign w_beat_idx = w_idle ? w_start_idx : r_next_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_beats_left <= 4'd0;
            r_next_idx   <= '0;
            r_data_valid <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_data_valid <= w_rd_beat;
            r_error      <= w_idle && enable && w_reject;
            if (w_accept) begin
                // Single-word requests complete on the accept edge itself.
                if (w_len_m1 != 4'd0) begin
                    r_state      <= rw ? ST_RD_BURST : ST_WR_BURST;
                    r_beats_left <= w_len_m1;
                    r_next_idx   <= w_start_idx + IDX_W'(1);
                end
            end else if (!w_idle) begin
                r_beats_left <= r_beats_left - 4'd1;
                r_next_idx   <= r_next_idx + IDX_W'(1);
                if (r_beats_left == 4'd1) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    mem_word_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_wr_beat),
        .i_re    (w_rd_beat),
        .i_addr  (w_beat_idx),
        .i_wdata (data_in),
        .o_rdata (data_out)
    );

    assign busy       = !w_idle;
    assign data_valid = r_data_valid;
    assign error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_responder.sv
// ============================================================================
// tb_mem_burst_responder : directed self-checking bench for mem_burst_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_burst_responder;

    localparam logic [31:0] BASE = 32'h80020000;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt;

    mem_burst_responder dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data_in     (data_in),
        .access_size (access_size),
        .rw          (rw),
        .enable      (enable),
        .busy        (busy),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .error       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr1(input logic [31:0] addr, input logic [31:0] data);
        enable = 1'b1; rw = 1'b0; access_size = 2'b00; address = addr; data_in = data;
        tick();
        enable = 1'b0;
        chk("wr1_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic rd1(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        enable = 1'b1; rw = 1'b1; access_size = 2'b00; address = addr;
        tick();
        enable = 1'b0;
        chk({tag, "_dv"}, {31'd0, data_valid}, 32'd1);
        chk({tag, "_data"}, data_out, exp);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rw = 1'b0; access_size = 2'b00;
        address = BASE; data_in = 32'd0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_err", {31'd0, error}, 32'd0);
        reset = 1'b0;
        tick();

        // Single write then single read
        wr1(BASE, 32'h8FA40000);
        rd1("single_rd", BASE, 32'h8FA40000);
        chk("single_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("single_dv_drop", {31'd0, data_valid}, 32'd0);
        chk("single_hold", data_out, 32'h8FA40000);

        // Four single writes, then burst-4 read
        wr1(BASE + 32'd0,  32'h11);
        wr1(BASE + 32'd4,  32'h22);
        wr1(BASE + 32'd8,  32'h33);
        wr1(BASE + 32'd12, 32'h44);
        enable = 1'b1; rw = 1'b1; access_size = 2'b01; address = BASE;
        busy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            enable = 1'b0;
            chk("b4_dv", {31'd0, data_valid}, 32'd1);
            chk("b4_data", data_out, 32'h11 * (k + 1));
            if (busy) busy_cnt++;
        end
        chk("b4_busy_cycles", busy_cnt, 32'd3);
        tick();
        chk("b4_dv_end", {31'd0, data_valid}, 32'd0);
        chk("b4_hold", data_out, 32'h44);

        // Burst-16 write; enable dropped and address changed from beat 5
        enable = 1'b1; rw = 1'b0; access_size = 2'b11; address = BASE;
        for (int k = 0; k < 16; k++) begin
            data_in = 32'hA0000000 + k;
            if (k >= 5) begin
                enable = 1'b0;
                address = BASE + 32'h200;
                rw = 1'b1;
            end
            tick();
            if (k < 15) chk("b16w_busy", {31'd0, busy}, 32'd1);
        end
        chk("b16w_done", {31'd0, busy}, 32'd0);
        chk("b16w_nodv", {31'd0, data_valid}, 32'd0);
        enable = 1'b1; rw = 1'b1; access_size = 2'b11; address = BASE;
        for (int k = 0; k < 16; k++) begin
            tick();
            enable = 1'b0;
            chk("b16r_data", data_out, 32'hA0000000 + k);
        end
        chk("b16r_idle", {31'd0, busy}, 32'd0);
        tick();

        // Reset during beat 3 of a burst-8 read
        enable = 1'b1; rw = 1'b1; access_size = 2'b10; address = BASE;
        tick();
        enable = 1'b0;
        tick();
        tick();
        chk("b8_pre_data", data_out, 32'hA0000002);
        chk("b8_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_dv", {31'd0, data_valid}, 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        #2 reset = 1'b0;
        rd1("post_rst_rd", BASE + 32'd4, 32'hA0000001);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Burst-4 write straddling the top of the array
        wr1(BASE + 32'hFF8, 32'hC0);
        wr1(BASE + 32'hFFC, 32'hC1);
        enable = 1'b1; rw = 1'b0; access_size = 2'b01; address = BASE + 32'hFF8;
        data_in = 32'hB0;
        tick();
        enable = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        chk("oor_err", {31'd0, error}, 32'd1);
        chk("oor_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("oor_err_pulse", {31'd0, error}, 32'd0);
        rd1("oor_w1022", BASE + 32'hFF8, 32'hC0);
        rd1("oor_w1023", BASE + 32'hFFC, 32'hC1);
        rd1("oor_w0", BASE, 32'hA0000000);
        rd1("oor_w1", BASE + 32'd4, 32'hA0000001);
`else
        chk("wrap_err", {31'd0, error}, 32'd0);
        chk("wrap_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k < 4; k++) begin
            data_in = 32'hB0 + k;
            tick();
            chk("wrap_err_hi", {31'd0, error}, 32'd0);
        end
        chk("wrap_done", {31'd0, busy}, 32'd0);
        rd1("wrap_w1022", BASE + 32'hFF8, 32'hB0);
        rd1("wrap_w1023", BASE + 32'hFFC, 32'hB1);
        rd1("wrap_w0", BASE, 32'hB2);
        rd1("wrap_w1", BASE + 32'd4, 32'hB3);
        rd1("wrap_w2", BASE + 32'd8, 32'hA0000002);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
